vend_multi: RTL and testbench
=============================

Name: vend_multi

Overview:
Parametrised newspaper/item vending controller. Generalises the two-product, two-coin machine to NUM_ITEMS products, each with its own price and stock counter. Adds change return, cancel/refund, sold-out detection and an inactivity timeout. Sits between the coin acceptor and select push-buttons on one side, and the dispense solenoids, LEDs, buzzer and 7-segment display on the other.

Parameters:
NUM_ITEMS, 4, number of products (2..8).
CREDIT_W, 6, width of credit, price and change values.
COIN_VAL1, 5, credit value of coin code 01.
COIN_VAL2, 10, credit value of coin code 10.
PRICES, {6'd25,6'd20,6'd15,6'd15}, packed price table; item i price = PRICES[i*CREDIT_W +: CREDIT_W].
STOCK_W, 4, width of each stock counter.
STOCK_INIT, 3, stock loaded into every item on reset.
TIMEOUT_CYC, 100, idle cycles in COLLECT before auto-refund.
ALARM_CYC, 8, cycles buzzer and red_led stay on in ERROR.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
in  input  2  coin code per cycle: 00 none, 01 COIN_VAL1, 10 COIN_VAL2, 11 invalid.
sel  input  NUM_ITEMS  item select buttons; one-hot expected.
cancel  input  1  refund request.
dispense  output  NUM_ITEMS  one-cycle pulse on the vended item's bit.
change_valid  output  1  one-cycle pulse; change_amt is valid.
change_amt  output  CREDIT_W  amount returned.
credit  output  CREDIT_W  current accumulated credit.
green_led  output  1  high during VEND.
red_led  output  1  high for one cycle on coin reject; high throughout ERROR.
buzzer  output  1  high throughout ERROR.
ssd  output  7  display pattern, segments gfedcba, active-high.

Behaviour:
- Reset (clk edge with rst=1): state IDLE, credit=0, all stock=STOCK_INIT, timer=0.
- Reset values of outputs: all outputs 0, except ssd='-' (7'b1000000).
- All outputs are registered. rst mid-transaction discards credit; no change is issued.
- FSM states: IDLE, COLLECT, VEND, CHANGE, ERROR.
- IDLE:
  - sel exactly one-hot with that item's stock>0: latch item index, go to COLLECT.
  - sel one-hot with stock=0: go to ERROR.
  - sel zero or multi-hot: ignored.
  - Any nonzero in: rejected (red_led pulse); credit stays 0.
- COLLECT:
  - Coin codes 01/10 add their value; code 11 is rejected with a red_led pulse.
  - A coin sampled in cycle n is visible on credit in cycle n+1.
  - If credit+coin >= price, next state is VEND. Credit saturates at 2^CREDIT_W-1.
  - Timer resets on every accepted coin. When the timer reaches TIMEOUT_CYC, go to CHANGE with change_amt=credit (full refund).
  - cancel=1: go to CHANGE with a full refund. If a coin arrives in the same cycle, cancel wins and the coin is rejected (red_led pulse).
  - sel is ignored.
- VEND (one cycle):
  - dispense[item]=1, green_led=1, stock[item] decrements.
  - Next state is CHANGE when credit>price (change_amt=credit-price); otherwise IDLE with credit cleared.
- CHANGE (one cycle): change_valid=1 with change_amt held; credit cleared to 0; next state IDLE.
- ERROR: buzzer=1, red_led=1 for exactly ALARM_CYC cycles, then IDLE. All inputs are ignored.
- Stock never underflows: a stock=0 item can never reach VEND.
- ssd content:
  - IDLE: '-'.
  - COLLECT/VEND/CHANGE: hex digit of the item index.
  - ERROR: 'E' (7'b1111001).

Optional Feature:
RESTOCK_EN:
- When defined: adds input port restock (1 bit). restock=1 while in IDLE reloads every stock counter to STOCK_INIT in the next cycle; it is ignored in other states.
- When undefined: no restock port exists, and stock reloads only on rst.

Test Plan:
1. Default params. Reset, sel=0001, coins 01,10 -> credit 5 then 15; dispense=0001 one cycle; no change_valid; stock[0]=2; back to IDLE.
2. sel=0100 (price 20), coins 10,10,10 -> at credit 20 the third coin is not needed. Instead use coins 10,01,10: credit 10,15, then 25 -> dispense=0100, then change_valid=1 with change_amt=5.
3. sel=1000, coin 10, then cancel asserted together with coin 01 -> red_led pulse, change_valid with change_amt=10, no dispense.
4. sel=0010, coin 01, then 100 idle cycles -> change_valid with change_amt=5 at the timeout cycle; state returns to IDLE.
5. Vend item0 three times, then sel=0001 again -> ERROR: buzzer and red_led high 8 cycles, ssd='E', no dispense. Also: in=11 in COLLECT -> red_led pulse, credit unchanged.
6. rst asserted in COLLECT with credit=10 -> credit=0, no change_valid, stock reloaded to 3. With RESTOCK_EN: restock pulse in IDLE after emptying item0 -> item0 vends again.

Source files
------------

// File: rtl/vend_multi.sv
// Multi-item vending controller: coin collection, change return, cancel/refund, sold-out alarm, inactivity timeout.
// Optional feature macro RESTOCK_EN adds a 'restock' input that reloads every stock counter from IDLE.
module vend_multi #(
    parameter int                             NUM_ITEMS   = 4,
    parameter int                             CREDIT_W    = 6,
    parameter int                             COIN_VAL1   = 5,
    parameter int                             COIN_VAL2   = 10,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0]  PRICES      = {6'd25, 6'd20, 6'd15, 6'd15},
    parameter int                             STOCK_W     = 4,
    parameter int                             STOCK_INIT  = 3,
    parameter int                             TIMEOUT_CYC = 100,
    parameter int                             ALARM_CYC   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           in,
    input  logic [NUM_ITEMS-1:0] sel,
    input  logic                 cancel,
`ifdef RESTOCK_EN
    input  logic                 restock,
`endif
    output logic [NUM_ITEMS-1:0] dispense,
    output logic                 change_valid,
    output logic [CREDIT_W-1:0]  change_amt,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 green_led,
    output logic                 red_led,
    output logic                 buzzer,
    output logic [6:0]           ssd
);

    localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int ALM_W = $clog2(ALARM_CYC + 1);

    localparam logic [CREDIT_W-1:0] VAL1       = CREDIT_W'(COIN_VAL1);
    localparam logic [CREDIT_W-1:0] VAL2       = CREDIT_W'(COIN_VAL2);
    localparam logic [TMR_W-1:0]    TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [ALM_W-1:0]    ALM_LAST   = ALM_W'(ALARM_CYC - 1);
    localparam logic [STOCK_W-1:0]  STOCK_FULL = STOCK_W'(STOCK_INIT);
    localparam logic [6:0]          SEG_DASH   = 7'b1000000;
    localparam logic [6:0]          SEG_E      = 7'b1111001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_CHANGE,
        S_ERROR
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       item_q, item_d;
    logic [CREDIT_W-1:0]    credit_q, credit_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [ALM_W-1:0]       alarmCnt_q, alarmCnt_d;
    logic [STOCK_W-1:0]     stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0]     stock_d [NUM_ITEMS];

    logic [NUM_ITEMS-1:0]   dispense_q, dispense_d;
    logic                   changeValid_q, changeValid_d;
    logic [CREDIT_W-1:0]    changeAmt_q, changeAmt_d;
    logic                   green_q, green_d;
    logic                   red_q, red_d;
    logic                   buzzer_q, buzzer_d;
    logic [6:0]             ssd_q, ssd_d;

    logic [CREDIT_W-1:0]    priceTab [NUM_ITEMS];
    logic [CREDIT_W-1:0]    price;
    logic [IDX_W-1:0]       selIdx;
    logic                   selOneHot;
    logic                   coinValid;
    logic [CREDIT_W-1:0]    coinVal;
    logic [CREDIT_W:0]      coinSum;
    logic [CREDIT_W-1:0]    creditSat;
    logic                   coinRej;
    logic [CREDIT_W-1:0]    chg_d;

    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_price
        assign priceTab[g] = PRICES[g*CREDIT_W +: CREDIT_W];
    end

    assign price     = priceTab[item_q];
    assign selOneHot = $onehot(sel);

    always_comb begin
        selIdx = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel[i]) selIdx = IDX_W'(i);
        end
    end

    // Saturating credit update: the carry out of the extra bit clamps to all-ones.
    always_comb begin
        coinValid = 1'b0;
        coinVal   = '0;
        case (in)
            2'b01: begin coinValid = 1'b1; coinVal = VAL1; end
            2'b10: begin coinValid = 1'b1; coinVal = VAL2; end
            default: begin coinValid = 1'b0; coinVal = '0; end
        endcase
    end

    assign coinSum   = {1'b0, credit_q} + {1'b0, coinVal};
    assign creditSat = coinSum[CREDIT_W] ? '1 : coinSum[CREDIT_W-1:0];

    function automatic logic [6:0] hexSeg(input logic [3:0] d);
        case (d)
            4'h0: hexSeg = 7'h3F;
            4'h1: hexSeg = 7'h06;
            4'h2: hexSeg = 7'h5B;
            4'h3: hexSeg = 7'h4F;
            4'h4: hexSeg = 7'h66;
            4'h5: hexSeg = 7'h6D;
            4'h6: hexSeg = 7'h7D;
            4'h7: hexSeg = 7'h07;
            4'h8: hexSeg = 7'h7F;
            4'h9: hexSeg = 7'h6F;
            4'hA: hexSeg = 7'h77;
            4'hB: hexSeg = 7'h7C;
            4'hC: hexSeg = 7'h39;
            4'hD: hexSeg = 7'h5E;
            4'hE: hexSeg = 7'h79;
            default: hexSeg = 7'h71;
        endcase
    endfunction

    // Next-state logic; chg_d carries the amount to present when entering CHANGE.
    always_comb begin
        state_d    = state_q;
        item_d     = item_q;
        credit_d   = credit_q;
        timer_d    = timer_q;
        alarmCnt_d = alarmCnt_q;
        chg_d      = '0;
        coinRej    = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = stock_q[i];

        case (state_q)
            S_IDLE: begin
                credit_d = '0;
                coinRej  = (in != 2'b00);
                if (selOneHot) begin
                    if (stock_q[selIdx] != '0) begin
                        state_d = S_COLLECT;
                        item_d  = selIdx;
                        timer_d = '0;
                    end else begin
                        state_d    = S_ERROR;
                        alarmCnt_d = '0;
                    end
                end
`ifdef RESTOCK_EN
                if (restock) begin
                    for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = STOCK_FULL;
                end
`endif
            end
            S_COLLECT: begin
                if (cancel) begin
                    state_d  = S_CHANGE;
                    chg_d    = credit_q;
                    credit_d = '0;
                    coinRej  = (in != 2'b00);
                end else if (coinValid) begin
                    credit_d = creditSat;
                    timer_d  = '0;
                    if (creditSat >= price) state_d = S_VEND;
                end else begin
                    coinRej = (in == 2'b11);
                    if (timer_q == TMR_LAST) begin
                        state_d  = S_CHANGE;
                        chg_d    = credit_q;
                        credit_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            S_VEND: begin
                coinRej  = (in != 2'b00);
                credit_d = '0;
                if (stock_q[item_q] != '0) stock_d[item_q] = stock_q[item_q] - STOCK_W'(1);
                if (credit_q > price) begin
                    state_d = S_CHANGE;
                    chg_d   = credit_q - price;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHANGE: begin
                coinRej  = (in != 2'b00);
                credit_d = '0;
                state_d  = S_IDLE;
            end
            S_ERROR: begin
                credit_d = '0;
                if (alarmCnt_q == ALM_LAST) state_d = S_IDLE;
                else alarmCnt_d = alarmCnt_q + ALM_W'(1);
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state they describe.
    always_comb begin
        dispense_d    = '0;
        changeValid_d = 1'b0;
        changeAmt_d   = '0;
        green_d       = 1'b0;
        red_d         = coinRej;
        buzzer_d      = 1'b0;
        ssd_d         = SEG_DASH;
        case (state_d)
            S_COLLECT: ssd_d = hexSeg(4'(item_d));
            S_VEND: begin
                dispense_d = NUM_ITEMS'(1) << item_d;
                green_d    = 1'b1;
                ssd_d      = hexSeg(4'(item_d));
            end
            S_CHANGE: begin
                changeValid_d = 1'b1;
                changeAmt_d   = chg_d;
                ssd_d         = hexSeg(4'(item_d));
            end
            S_ERROR: begin
                red_d    = 1'b1;
                buzzer_d = 1'b1;
                ssd_d    = SEG_E;
            end
            default: ssd_d = SEG_DASH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            item_q        <= '0;
            credit_q      <= '0;
            timer_q       <= '0;
            alarmCnt_q    <= '0;
            for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_FULL;
            dispense_q    <= '0;
            changeValid_q <= 1'b0;
            changeAmt_q   <= '0;
            green_q       <= 1'b0;
            red_q         <= 1'b0;
            buzzer_q      <= 1'b0;
            ssd_q         <= SEG_DASH;
        end else begin
            state_q       <= state_d;
            item_q        <= item_d;
            credit_q      <= credit_d;
            timer_q       <= timer_d;
            alarmCnt_q    <= alarmCnt_d;
            for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= stock_d[i];
            dispense_q    <= dispense_d;
            changeValid_q <= changeValid_d;
            changeAmt_q   <= changeAmt_d;
            green_q       <= green_d;
            red_q         <= red_d;
            buzzer_q      <= buzzer_d;
            ssd_q         <= ssd_d;
        end
    end

    assign dispense     = dispense_q;
    assign change_valid = changeValid_q;
    assign change_amt   = changeAmt_q;
    assign credit       = credit_q;
    assign green_led    = green_q;
    assign red_led      = red_q;
    assign buzzer       = buzzer_q;
    assign ssd          = ssd_q;

endmodule

// File: tb/tb_vend_multi.sv
// Testbench for vend_multi: directed sessions then random sessions against a transaction-level model
// (price table, per-item stock counts, running credit). Define RESTOCK_EN to also exercise restock.
module tb_vend_multi;

    localparam int N        = 4;
    localparam int CW       = 6;
    localparam int COIN1    = 5;
    localparam int COIN2    = 10;
    localparam int TIMEOUT  = 100;
    localparam int ALARM    = 8;
    localparam int SEG_DASH = 7'h40;
    localparam int SEG_E    = 7'h79;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    coinIn;
    logic [N-1:0]  sel;
    logic          cancel;
`ifdef RESTOCK_EN
    logic          restock;
`endif
    logic [N-1:0]  dispense;
    logic          change_valid;
    logic [CW-1:0] change_amt;
    logic [CW-1:0] credit;
    logic          green_led;
    logic          red_led;
    logic          buzzer;
    logic [6:0]    ssd;

    int nAsserts = 0;
    int nFails   = 0;
    int priceTab[N] = '{15, 15, 20, 25};
    int stockModel[N];
    int coinSeq[$];

    vend_multi dut (
        .clk          (clk),
        .rst          (rst),
        .in           (coinIn),
        .sel          (sel),
        .cancel       (cancel),
`ifdef RESTOCK_EN
        .restock      (restock),
`endif
        .dispense     (dispense),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .credit       (credit),
        .green_led    (green_led),
        .red_led      (red_led),
        .buzzer       (buzzer),
        .ssd          (ssd)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int segDigit(input int d);
        case (d)
            0: segDigit = 7'h3F;
            1: segDigit = 7'h06;
            2: segDigit = 7'h5B;
            3: segDigit = 7'h4F;
            4: segDigit = 7'h66;
            5: segDigit = 7'h6D;
            6: segDigit = 7'h7D;
            default: segDigit = 7'h07;
        endcase
    endfunction

    task automatic applyStimulus(input logic [1:0] code, input logic [N-1:0] s, input logic canc);
        coinIn = code;
        sel    = s;
        cancel = canc;
        @(posedge clk);
        #1;
    endtask

    task automatic idleTick();
        applyStimulus(2'b00, N'(0), 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int eDisp, input int eCv, input int eAmt,
                            input int eCredit, input int eGreen, input int eRed, input int eBuzz,
                            input int eSsd);
        checkOutput({tag, ".dispense"},     32'(dispense),     eDisp);
        checkOutput({tag, ".change_valid"}, 32'(change_valid), eCv);
        if (eAmt >= 0) checkOutput({tag, ".change_amt"}, 32'(change_amt), eAmt);
        checkOutput({tag, ".credit"},       32'(credit),       eCredit);
        checkOutput({tag, ".green_led"},    32'(green_led),    eGreen);
        checkOutput({tag, ".red_led"},      32'(red_led),      eRed);
        checkOutput({tag, ".buzzer"},       32'(buzzer),       eBuzz);
        checkOutput({tag, ".ssd"},          32'(ssd),          eSsd);
    endtask

    // One customer session: select an item, then feed coinSeq (cancelling at cancelAt).
    // If the coins run out, the session is cancelled unless leaveOpen keeps it in collection.
    task automatic runSession(input int item, input int cancelAt, input bit leaveOpen);
        int c;
        int price;
        int code;
        int v;
        int seg;
        c     = 0;
        price = priceTab[item];
        seg   = segDigit(item);
        applyStimulus(2'b00, N'(1) << item, 1'b0);
        if (stockModel[item] == 0) begin
            for (int k = 0; k < ALARM; k++) begin
                checkAll("soldout", 0, 0, -1, 0, 0, 1, 1, SEG_E);
                applyStimulus(2'($urandom_range(0, 3)), N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
            checkAll("afterErr", 0, 0, -1, 0, 0, 0, 0, SEG_DASH);
            return;
        end
        checkAll("selected", 0, 0, -1, 0, 0, 0, 0, seg);
        for (int idx = 0; idx < 64; idx++) begin
            if (idx == cancelAt || (idx >= coinSeq.size() && !leaveOpen)) begin
                code = (idx < coinSeq.size()) ? coinSeq[idx] : 0;
                applyStimulus(2'(code), N'($urandom_range(0, 15)), 1'b1);
                checkAll("cancel", 0, 1, c, 0, 0, int'(code != 0), 0, seg);
                idleTick();
                checkAll("afterCancel", 0, 0, -1, 0, 0, 0, 0, SEG_DASH);
                return;
            end
            if (idx >= coinSeq.size()) return;
            code = coinSeq[idx];
            v = (code == 1) ? COIN1 : (code == 2) ? COIN2 : 0;
            applyStimulus(2'(code), N'($urandom_range(0, 15)), 1'b0);
            if (v != 0) begin
                c = c + v;
                if (c > 63) c = 63;
            end
            if (c >= price) begin
                checkAll("vend", 1 << item, 0, -1, c, 1, 0, 0, seg);
                stockModel[item]--;
                idleTick();
                if (c > price) begin
                    checkAll("change", 0, 1, c - price, 0, 0, 0, 0, seg);
                    idleTick();
                end
                checkAll("afterVend", 0, 0, -1, 0, 0, 0, 0, SEG_DASH);
                return;
            end
            checkAll("collect", 0, 0, -1, c, 0, int'(code == 3), 0, seg);
        end
    endtask

    initial begin
        int r;
        int item;
        int cancelAt;
        rst    = 1'b1;
        coinIn = 2'b00;
        sel    = '0;
        cancel = 1'b0;
`ifdef RESTOCK_EN
        restock = 1'b0;
`endif
        for (int i = 0; i < N; i++) stockModel[i] = 3;
        idleTick();
        idleTick();
        checkAll("reset", 0, 0, 0, 0, 0, 0, 0, SEG_DASH);
        rst = 1'b0;

        $display("[TB] item0 exact payment");
        coinSeq = '{1, 2};
        runSession(0, -1, 1'b0);

        $display("[TB] item2 overpay with change");
        coinSeq = '{2, 1, 2};
        runSession(2, -1, 1'b0);

        $display("[TB] item3 cancel with simultaneous coin");
        coinSeq = '{2, 1};
        runSession(3, 1, 1'b0);

        $display("[TB] item1 inactivity timeout");
        coinSeq = '{1};
        runSession(1, -1, 1'b1);
        for (int k = 1; k < TIMEOUT; k++) begin
            idleTick();
            checkOutput("timeoutWait.change_valid", 32'(change_valid), 0);
            checkOutput("timeoutWait.credit", 32'(credit), 5);
        end
        idleTick();
        checkAll("timeout", 0, 1, 5, 0, 0, 0, 0, segDigit(1));
        idleTick();
        checkAll("afterTimeout", 0, 0, -1, 0, 0, 0, 0, SEG_DASH);

        $display("[TB] empty item0, invalid coin, then sold out");
        coinSeq = '{3, 2, 1};
        runSession(0, -1, 1'b0);
        coinSeq = '{2, 2};
        runSession(0, -1, 1'b0);
        coinSeq = '{2, 2};
        runSession(0, -1, 1'b0);

`ifdef RESTOCK_EN
        $display("[TB] restock in IDLE");
        restock = 1'b1;
        idleTick();
        restock = 1'b0;
        checkAll("restock", 0, 0, -1, 0, 0, 0, 0, SEG_DASH);
        for (int i = 0; i < N; i++) stockModel[i] = 3;
        coinSeq = '{2, 1};
        runSession(0, -1, 1'b0);
`endif

        $display("[TB] idle coin reject and multi-hot select");
        applyStimulus(2'b10, N'(0), 1'b0);
        checkAll("idleCoin", 0, 0, -1, 0, 0, 1, 0, SEG_DASH);
        applyStimulus(2'b00, N'(3), 1'b0);
        checkAll("multiHot", 0, 0, -1, 0, 0, 0, 0, SEG_DASH);

        $display("[TB] reset during collection");
        coinSeq = '{2};
        runSession(3, -1, 1'b1);
        rst = 1'b1;
        idleTick();
        rst = 1'b0;
        checkAll("midReset", 0, 0, -1, 0, 0, 0, 0, SEG_DASH);
        for (int i = 0; i < N; i++) stockModel[i] = 3;
        coinSeq = '{2, 1};
        runSession(0, -1, 1'b0);

        $display("[TB] random sessions");
        for (int s = 0; s < 40; s++) begin
            item = $urandom_range(0, N - 1);
            coinSeq.delete();
            for (int k = 0; k < 12; k++) begin
                r = $urandom_range(0, 9);
                if (r < 2) coinSeq.push_back(0);
                else if (r < 9) coinSeq.push_back((r % 2) + 1);
                else coinSeq.push_back(3);
            end
            cancelAt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(2'($urandom_range(1, 3)), N'(0), 1'b0);
                checkAll("randIdleCoin", 0, 0, -1, 0, 0, 1, 0, SEG_DASH);
            end
            runSession(item, cancelAt, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
